ss_key_det: RTL
===============

SS_KEY_DET -- requirements
Module: ss_key_det

Interface
REQ-001 Parameter HOLD_POLLS, default 3: consecutive completed matching polls required before a request fires (range 1-15).
REQ-002 Parameter DEBOUNCE_CYC, default 65535: clk cycles ss_btn must be stable before it is accepted.
REQ-003 clk  input  1  system clock, all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert and active-low.
REQ-005 cpu_addr  input  16  CPU address bus.
REQ-006 cpu_rw  input  1  CPU direction: 1 is read, 0 is write.
REQ-007 m2  input  1  CPU phase-2 clock; asynchronous to clk.
REQ-008 cpu_dat  input  8  CPU data bus as seen at the cartridge edge.
REQ-009 cfg  input  SysCfg  configuration; uses ss_key_save, ss_key_load, ss_key_menu, ct_ss_on and ct_ss_btn.
REQ-010 ss_btn  input  1  external in-game-menu button, active-low, asynchronous.
REQ-011 pad_state  output  8  last complete pad-1 poll; bit0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right; 1 means pressed.
REQ-012 pad_valid  output  1  one-cycle pulse when pad_state updates.
REQ-013 ss_req_save / ss_req_load / ss_req_menu  output  1 each  one-cycle request pulses.

Function
REQ-014 m2, ss_btn: each SHALL pass through a 2-flop synchronizer; a CPU bus cycle is taken at the synchronized m2 falling edge, sampling cpu_addr/cpu_rw/cpu_dat registered one clk earlier.
REQ-015 Write to 0x4016: strobe SHALL latch cpu_dat[0]; a 1->0 transition SHALL clear the bit counter to 0 and the shift register to 0.
REQ-016 Read of 0x4016 with strobe=0 and counter<8: bit[counter] of the shift register SHALL be set to cpu_dat[0], and the counter SHALL increment.
REQ-017 The read bringing counter to 8: pad_state SHALL load the shift register on the next clk, and pad_valid SHALL pulse once; later reads SHALL be ignored until the next strobe 1->0.
REQ-018 Reads with strobe=1, reads or writes to 0x4017, and all other addresses SHALL not affect the counter.
REQ-019 Per key K (menu, save, load): on pad_valid, if K!=0 and pad_state==K, then hold_K SHALL increment, saturating at HOLD_POLLS; otherwise hold_K SHALL clear to 0 and armed_K SHALL set.
REQ-020 When hold_K reaches HOLD_POLLS with armed_K=1, ss_req_K SHALL pulse on the clk after pad_valid, and armed_K SHALL clear (one request per press; re-arm needs a non-matching poll).
REQ-021 Equal keys: only the highest priority SHALL fire, with priority menu > save > load; lower-priority keys SHALL be disarmed the same cycle.
REQ-022 K==0 SHALL never match.
REQ-023 ct_ss_on=0 SHALL force all hold counters to 0, all armed flags to 1, and suppress key-derived pulses; pad_state decoding SHALL continue.
REQ-024 ct_ss_btn=1: the synchronized ss_btn SHALL be debounced (counter reloads on any change; accepted after DEBOUNCE_CYC stable cycles).
REQ-025 An accepted 1->0 ss_btn transition SHALL pulse ss_req_menu once, independent of ct_ss_on; a pulse coincident with a key-derived menu pulse SHALL merge into one pulse.
REQ-026 ct_ss_btn=0: ss_btn SHALL be ignored and its debounce state held at released.
REQ-027 At most one of the three request outputs SHALL be high in any cycle; a menu request SHALL win if sources coincide.

Reset
REQ-028 rst_n low SHALL immediately clear pad_state, pad_valid, all request outputs, the counter, the shift register, strobe and hold counters; armed flags SHALL be 1 and debounce state released (1).
REQ-029 Reset asserted mid-poll SHALL discard the partial poll; the first poll after reset SHALL require a fresh strobe 1->0.

Verification
REQ-030 Write 0x4016=1 then 0; 8 reads with D0 pattern 1,0,0,1,0,0,0,0 -> pad_state=0x09, one pad_valid pulse.
REQ-031 ss_key_save=0x09, ct_ss_on=1, HOLD_POLLS=3, four polls of 0x09 -> exactly one ss_req_save after poll 3; after a poll of 0x00 then three of 0x09 -> a second pulse.
REQ-032 ss_key_menu=ss_key_save=0x30, three polls of 0x30 -> ss_req_menu only, with ss_req_save never asserted.
REQ-033 A 9th and 10th read after a complete poll, and 0x4017 reads -> pad_state unchanged, no pad_valid.
REQ-034 ct_ss_btn=1, DEBOUNCE_CYC=16: ss_btn low for 10 cycles -> no pulse; low for 20 cycles -> one ss_req_menu; with ct_ss_btn=0 -> none.
REQ-035 rst_n pulsed low after 4 reads of a poll -> all outputs 0; the next 8 reads without a new strobe produce no pad_valid.

Source files
------------

// File: rtl/ss_key_det.sv
// ss_key_det: save-state hot-key detector.
// Snoops NES pad-1 polls ($4016 strobe/read) on the CPU bus and publishes
// the decoded pad byte. It then raises menu/save/load requests when a
// configured key combination is held for HOLD_POLLS polls, or when the
// debounced external menu button is pressed.
// Ports:
//   clk, rst_n        system clock, async active-low reset
//   cpu_addr/rw/dat   CPU bus as seen at the cartridge edge
//   m2                CPU phase-2 clock (async to clk)
//   cfg               key combinations and enables
//   ss_btn            external menu button, active-low, async
//   pad_state/valid   last complete poll and its one-cycle update pulse
//   ss_req_*          one-cycle request pulses, at most one high per cycle

package ss_key_det_pkg;
    typedef struct packed {
        logic [7:0] ss_key_save;
        logic [7:0] ss_key_load;
        logic [7:0] ss_key_menu;
        logic       ct_ss_on;
        logic       ct_ss_btn;
    } SysCfg;
endpackage

module ss_key_det
    import ss_key_det_pkg::*;
#(
    parameter int unsigned HOLD_POLLS   = 3,
    parameter int unsigned DEBOUNCE_CYC = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rw,
    input  logic        m2,
    input  logic [7:0]  cpu_dat,
    input  SysCfg       cfg,
    input  logic        ss_btn,
    output logic [7:0]  pad_state,
    output logic        pad_valid,
    output logic        ss_req_save,
    output logic        ss_req_load,
    output logic        ss_req_menu
);

    localparam int unsigned HOLD_W = 4;
    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam int unsigned NKEY   = 3;   // 0 menu, 1 save, 2 load (priority order)

    logic              m2_s1_q, m2_s1_d, m2_s2_q, m2_s2_d, m2_prev_q, m2_prev_d;
    logic              btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
    logic [15:0]       addr_q, addr_d;
    logic              rw_q, rw_d;
    logic [7:0]        dat_q, dat_d;
    logic              strobe_q, strobe_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              poll_en_q, poll_en_d;
    logic              load_q, load_d;
    logic [7:0]        pad_state_q, pad_state_d;
    logic              pad_valid_q, pad_valid_d;
    logic [HOLD_W-1:0] hold_q [NKEY];
    logic [HOLD_W-1:0] hold_d [NKEY];
    logic [NKEY-1:0]   armed_q, armed_d;
    logic              db_state_q, db_state_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic              req_save_q, req_save_d, req_load_q, req_load_d, req_menu_q, req_menu_d;

    logic [7:0]        keys [NKEY];
    logic              m2_fall;
    logic [NKEY-1:0]   match, raw_fire, fire;
    logic              btn_press;

    assign keys[0] = cfg.ss_key_menu;
    assign keys[1] = cfg.ss_key_save;
    assign keys[2] = cfg.ss_key_load;

    // Next-state logic for bus snoop, pad decode, hold tracking and debounce.
    always_comb begin
        m2_s1_d     = m2;
        m2_s2_d     = m2_s1_q;
        m2_prev_d   = m2_s2_q;
        btn_s1_d    = ss_btn;
        btn_s2_d    = btn_s1_q;
        addr_d      = cpu_addr;
        rw_d        = cpu_rw;
        dat_d       = cpu_dat;
        strobe_d    = strobe_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        poll_en_d   = poll_en_q;
        load_d      = 1'b0;
        pad_state_d = pad_state_q;
        pad_valid_d = 1'b0;
        armed_d     = armed_q;
        db_state_d  = db_state_q;
        db_cnt_d    = db_cnt_q;
        match       = '0;
        raw_fire    = '0;
        fire        = '0;
        btn_press   = 1'b0;
        for (int k = 0; k < NKEY; k++) hold_d[k] = hold_q[k];

        // Bus cycle completes on the synchronized m2 falling edge.
        m2_fall = m2_prev_q & ~m2_s2_q;
        if (m2_fall && addr_q == 16'h4016) begin
            if (!rw_q) begin
                strobe_d = dat_q[0];
                // Strobe release starts a fresh poll; only this enables reads.
                if (strobe_q && !dat_q[0]) begin
                    cnt_d     = 4'd0;
                    shift_d   = 8'd0;
                    poll_en_d = 1'b1;
                end
            end else if (!strobe_q && poll_en_q && cnt_q < 4'd8) begin
                shift_d[cnt_q[2:0]] = dat_q[0];
                cnt_d               = cnt_q + 4'd1;
                if (cnt_q == 4'd7) begin
                    poll_en_d = 1'b0;
                    load_d    = 1'b1;
                end
            end
        end

        if (load_q) begin
            pad_state_d = shift_q;
            pad_valid_d = 1'b1;
        end

        // Hold tracking per key on each published poll.
        if (pad_valid_q) begin
            for (int k = 0; k < NKEY; k++) begin
                match[k] = (keys[k] != 8'd0) && (pad_state_q == keys[k]);
                if (match[k]) begin
                    if (hold_q[k] != HOLD_W'(HOLD_POLLS))
                        hold_d[k] = hold_q[k] + HOLD_W'(1);
                    raw_fire[k] = armed_q[k] && (hold_d[k] == HOLD_W'(HOLD_POLLS));
                    if (raw_fire[k]) armed_d[k] = 1'b0;
                end else begin
                    hold_d[k]  = '0;
                    armed_d[k] = 1'b1;
                end
            end
        end
        // A lower-priority key matching alongside a higher one has an equal
        // combination; it is disarmed above but never fires.
        fire[0] = raw_fire[0];
        fire[1] = raw_fire[1] & ~match[0];
        fire[2] = raw_fire[2] & ~match[0] & ~match[1];

        if (!cfg.ct_ss_on) begin
            for (int k = 0; k < NKEY; k++) hold_d[k] = '0;
            armed_d = '1;
            fire    = '0;
        end

        // Button debounce: counts cycles the input differs from the accepted level.
        if (!cfg.ct_ss_btn) begin
            db_state_d = 1'b1;
            db_cnt_d   = '0;
        end else if (btn_s2_q == db_state_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_W'(DEBOUNCE_CYC - 1)) begin
            db_state_d = btn_s2_q;
            db_cnt_d   = '0;
            btn_press  = db_state_q;
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end

        req_menu_d = fire[0] | btn_press;
        req_save_d = fire[1] & ~req_menu_d;
        req_load_d = fire[2] & ~req_menu_d & ~fire[1];
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m2_s1_q     <= 1'b0;
            m2_s2_q     <= 1'b0;
            m2_prev_q   <= 1'b0;
            btn_s1_q    <= 1'b1;
            btn_s2_q    <= 1'b1;
            addr_q      <= 16'd0;
            rw_q        <= 1'b1;
            dat_q       <= 8'd0;
            strobe_q    <= 1'b0;
            cnt_q       <= 4'd0;
            shift_q     <= 8'd0;
            poll_en_q   <= 1'b0;
            load_q      <= 1'b0;
            pad_state_q <= 8'd0;
            pad_valid_q <= 1'b0;
            for (int k = 0; k < NKEY; k++) hold_q[k] <= '0;
            armed_q     <= '1;
            db_state_q  <= 1'b1;
            db_cnt_q    <= '0;
            req_save_q  <= 1'b0;
            req_load_q  <= 1'b0;
            req_menu_q  <= 1'b0;
        end else begin
            m2_s1_q     <= m2_s1_d;
            m2_s2_q     <= m2_s2_d;
            m2_prev_q   <= m2_prev_d;
            btn_s1_q    <= btn_s1_d;
            btn_s2_q    <= btn_s2_d;
            addr_q      <= addr_d;
            rw_q        <= rw_d;
            dat_q       <= dat_d;
            strobe_q    <= strobe_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            poll_en_q   <= poll_en_d;
            load_q      <= load_d;
            pad_state_q <= pad_state_d;
            pad_valid_q <= pad_valid_d;
            for (int k = 0; k < NKEY; k++) hold_q[k] <= hold_d[k];
            armed_q     <= armed_d;
            db_state_q  <= db_state_d;
            db_cnt_q    <= db_cnt_d;
            req_save_q  <= req_save_d;
            req_load_q  <= req_load_d;
            req_menu_q  <= req_menu_d;
        end
    end

    assign pad_state   = pad_state_q;
    assign pad_valid   = pad_valid_q;
    assign ss_req_save = req_save_q;
    assign ss_req_load = req_load_q;
    assign ss_req_menu = req_menu_q;

endmodule
